// File: rtl/uart_transmitter_if.sv
// Transmit handshake bundle for uart_transmitter.
//   XMIT_REQ  : request from the sender; XMIT_Data must stay valid while it is high
//   XMIT_Data : byte to transmit
//   XMIT_ACK  : byte accepted; held until the frame is done and XMIT_REQ is low
// master = sending side (CPU/bus), slave = transmitter.
interface uart_transmitter_if;
    logic       XMIT_REQ;
    logic [7:0] XMIT_Data;
    logic       XMIT_ACK;

    modport master (output XMIT_REQ, output XMIT_Data, input XMIT_ACK);
    modport slave  (input XMIT_REQ, input XMIT_Data, output XMIT_ACK);
endinterface

// File: rtl/uart_transmitter.sv
// UART transmitter: accepts one byte over a four-phase REQ/ACK handshake and
// shifts it out as start bit, 8 data bits LSB first, optional even parity,
// then STOP_BITS stop bits.
//
// Ports:
//   clk   : system clock, all logic on posedge
//   clr   : asynchronous active-low reset
//   xmit  : handshake bundle (uart_transmitter_if.slave)
//   TX    : serial line, idles high, registered
//   BUSY  : high whenever the FSM is not in IDLE, registered
//
// Parameters:
//   CLKS_PER_BIT : system clocks per bit time (2..65535)
//   STOP_BITS    : 1 or 2; any other value behaves as 1
//
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit(s).
//
// state  | meaning
// IDLE   | line high, waiting for XMIT_REQ
// START  | start bit (TX low)
// DATA   | 8 data bits, LSB first
// PARITY | even parity bit (only with UART_TX_PARITY_EN)
// STOP   | stop bit(s), TX high
// DONE   | frame sent, ACK held until XMIT_REQ drops
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 10424,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              clr,
    uart_transmitter_if.slave xmit,
    output logic              TX,
    output logic              BUSY
);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  STOP_LAST = (STOP_BITS == 2) ? 3'd1 : 3'd0;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP,
        DONE
    } state_t;

    state_t      state, state_next;
    logic [15:0] bit_timer;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift, shift_next;
    logic        ack_q;
    logic        tx_next, busy_next, ack_next;
    logic        bit_end;
`ifdef UART_TX_PARITY_EN
    logic        parity;
`endif

    assign bit_end       = (bit_timer == BIT_LAST);
    assign xmit.XMIT_ACK = ack_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (xmit.XMIT_REQ) state_next = START;
            START:  if (bit_end) state_next = DATA;
            DATA:
                if (bit_end && bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_end) state_next = STOP;
`endif
            STOP:   if (bit_end && bit_cnt == STOP_LAST) state_next = DONE;
            DONE:   if (!xmit.XMIT_REQ) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Shift register next value; TX is derived from it so the line is
    // already correct on the edge that enters a new bit.
    always_comb begin
        shift_next = shift;
        if (state == IDLE && xmit.XMIT_REQ)
            shift_next = xmit.XMIT_Data;
        else if (state == DATA && bit_end)
            shift_next = {1'b0, shift[7:1]};
    end

    // Outputs are decoded from the next state and registered below.
    always_comb begin
        tx_next   = 1'b1;
        busy_next = (state_next != IDLE);
        ack_next  = (state_next != IDLE);
        case (state_next)
            START:  tx_next = 1'b0;
            DATA:   tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_next = parity;
`endif
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            bit_timer <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            TX        <= 1'b1;
            BUSY      <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            shift <= shift_next;
            TX    <= tx_next;
            BUSY  <= busy_next;
            ack_q <= ack_next;
            // Timer restarts on every state entry and on every bit boundary;
            // bit_cnt counts data bits in DATA and stop bits in STOP.
            if (state_next != state || state == IDLE || state == DONE) begin
                bit_timer <= '0;
                bit_cnt   <= '0;
            end else if (bit_end) begin
                bit_timer <= '0;
                bit_cnt   <= bit_cnt + 3'd1;
            end else begin
                bit_timer <= bit_timer + 16'd1;
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or negedge clr) begin
        if (!clr)
            parity <= 1'b0;
        else if (state == IDLE && xmit.XMIT_REQ)
            parity <= ^xmit.XMIT_Data;
    end
`endif

endmodule

// File: tb/tb_uart_transmitter.sv
module tb_uart_transmitter;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    uart_transmitter_if xif1 ();
    uart_transmitter_if xif2 ();
    logic tx1, busy1, tx2, busy2;

    uart_transmitter #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut1 (
        .clk(clk), .clr(clr), .xmit(xif1), .TX(tx1), .BUSY(busy1));
    uart_transmitter #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
        .clk(clk), .clr(clr), .xmit(xif2), .TX(tx2), .BUSY(busy2));

    int   vectors     = 0;
    int   miscompares = 0;
    logic exp_q[$];
    bit   sel = 1'b0;

    task automatic chk(string tag, logic obs, logic exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic cur_tx();
        return sel ? tx2 : tx1;
    endfunction
    function automatic logic cur_busy();
        return sel ? busy2 : busy1;
    endfunction
    function automatic logic cur_ack();
        return sel ? xif2.XMIT_ACK : xif1.XMIT_ACK;
    endfunction

    task automatic drive(logic r, logic [7:0] d);
        if (sel) begin xif2.XMIT_REQ = r; xif2.XMIT_Data = d; end
        else     begin xif1.XMIT_REQ = r; xif1.XMIT_Data = d; end
    endtask

    // Expected line level for each bit time of one frame.
    task automatic push_frame(logic [7:0] d, int stops);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
        exp_q.push_back(^d);
`endif
        for (int s = 0; s < stops; s++) exp_q.push_back(1'b1);
    endtask

    // Called at the negedge where REQ is raised; returns at the negedge of the
    // first START clock after checking the one-clock accept latency.
    task automatic start_frame(logic [7:0] d, int stops, string tag);
        push_frame(d, stops);
        drive(1'b1, d);
        @(negedge clk);
        chk({tag, "_ack_rise"}, cur_ack(), 1'b1);
        chk({tag, "_tx_fall"}, cur_tx(), 1'b0);
    endtask

    // Entered on the first START clock; checks every clock of every bit and
    // returns on the first DONE clock.
    task automatic check_frame(string tag);
        int   nbits;
        logic e;
        nbits = exp_q.size();
        for (int b = 0; b < nbits; b++) begin
            e = exp_q.pop_front();
            for (int c = 0; c < CPB; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                chk($sformatf("%s_b%0d_c%0d", tag, b, c), cur_tx(), e);
            end
            chk($sformatf("%s_busy_b%0d", tag, b), cur_busy(), 1'b1);
        end
        @(negedge clk);
        chk({tag, "_done_tx"}, cur_tx(), 1'b1);
        chk({tag, "_done_busy"}, cur_busy(), 1'b1);
    endtask

    task automatic release_req(string tag);
        drive(1'b0, 8'h00);
        @(negedge clk);
        chk({tag, "_ack_fall"}, cur_ack(), 1'b0);
        chk({tag, "_busy_fall"}, cur_busy(), 1'b0);
        chk({tag, "_idle_tx"}, cur_tx(), 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr = 1'b0;
        xif1.XMIT_REQ = 1'b1; xif1.XMIT_Data = 8'h55;
        xif2.XMIT_REQ = 1'b0; xif2.XMIT_Data = 8'h00;

        // Reset held with REQ high: line idle, no ACK.
        repeat (5) begin
            @(negedge clk);
            chk("rst_tx", tx1, 1'b1);
            chk("rst_ack", xif1.XMIT_ACK, 1'b0);
            chk("rst_busy", busy1, 1'b0);
        end
        push_frame(8'h55, 1);
        clr = 1'b1;
        @(negedge clk);
        chk("rel_ack_rise", xif1.XMIT_ACK, 1'b1);
        chk("rel_tx_fall", tx1, 1'b0);
        check_frame("f55");

        // REQ still high: parked in DONE, no second frame.
        repeat (3 * CPB) begin
            @(negedge clk);
            chk("hold_tx", tx1, 1'b1);
            chk("hold_ack", xif1.XMIT_ACK, 1'b1);
            chk("hold_busy", busy1, 1'b1);
        end
        release_req("f55");

        // New frame after the four-phase return.
        start_frame(8'h00, 1, "f00");
        check_frame("f00");
        release_req("f00");

        // REQ dropped and data changed mid-frame; latched byte still sent.
        start_frame(8'hA3, 1, "fa3");
        fork
            check_frame("fa3");
            begin
                repeat (3 * CPB) @(negedge clk);
                drive(1'b0, 8'hFF);
                @(negedge clk);
                chk("fa3_ack_held", xif1.XMIT_ACK, 1'b1);
            end
        join
        @(negedge clk);
        chk("fa3_ack_fall", xif1.XMIT_ACK, 1'b0);
        chk("fa3_busy_fall", busy1, 1'b0);

        // Reset mid-frame while TX is low: line returns high at once.
        start_frame(8'h00, 1, "abort");
        repeat (3 * CPB) @(negedge clk);
        chk("abort_pre_tx", tx1, 1'b0);
        #2 clr = 1'b0;
        #1;
        chk("abort_tx", tx1, 1'b1);
        chk("abort_ack", xif1.XMIT_ACK, 1'b0);
        chk("abort_busy", busy1, 1'b0);
        @(negedge clk);
        drive(1'b0, 8'h00);
        clr = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        chk("abort_idle_tx", tx1, 1'b1);
        chk("abort_idle_busy", busy1, 1'b0);

        // Two stop bits.
        sel = 1'b1;
        start_frame(8'hFF, 2, "fff_2stop");
        check_frame("fff_2stop");
        release_req("fff_2stop");
        sel = 1'b0;

`ifdef UART_TX_PARITY_EN
        start_frame(8'h07, 1, "p07");
        check_frame("p07");
        release_req("p07");
        start_frame(8'h03, 1, "p03");
        check_frame("p03");
        release_req("p03");

        // Reset during a low parity bit.
        start_frame(8'h03, 1, "pabort");
        repeat (9 * CPB + CPB / 2) @(negedge clk);
        chk("pabort_pre_tx", tx1, 1'b0);
        #2 clr = 1'b0;
        #1;
        chk("pabort_tx", tx1, 1'b1);
        chk("pabort_busy", busy1, 1'b0);
        chk("pabort_ack", xif1.XMIT_ACK, 1'b0);
        @(negedge clk);
        drive(1'b0, 8'h00);
        clr = 1'b1;
        exp_q.delete();
        @(negedge clk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- Serial UART transmitter; the transmit-side companion to the team's UART receiver.
- Takes one byte from the CPU/bus side over a four-phase REQ/ACK handshake and shifts it out on TX as an 8N1 frame: start bit, 8 data bits LSB first, stop bit(s).
- Default timing matches the receiver's baud rate at the same system clock: 1303 clocks per sample × 8 samples per bit = 10424 clocks per bit.

Parameters:
CLKS_PER_BIT, 10424, system clocks per serial bit time; legal range 2..65535.
STOP_BITS, 1, number of stop bits transmitted; legal values 1 or 2.

Ports:
clk  input  1  system clock; all logic on posedge.
clr  input  1  asynchronous active-low reset.
XMIT_REQ  input  1  request from sender; XMIT_Data must be valid while high.
XMIT_Data  input  8  byte to transmit.
XMIT_ACK  output  1  byte accepted; held until frame done and XMIT_REQ low.
TX  output  1  serial line; idles high.
BUSY  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (clr low, asynchronous):
  - state=IDLE, TX=1, XMIT_ACK=0, BUSY=0.
  - Bit timer, bit counter and shift register cleared.
  - Reset mid-frame aborts the frame immediately; TX returns high with no glitch low.
- Bit timer: 16-bit counter, counts 0..CLKS_PER_BIT-1. Reload to 0 on every state entry. "Bit end" = timer==CLKS_PER_BIT-1.
- All outputs are registered; TX never comes from combinational logic.
- States:
  - IDLE: TX=1, ACK=0.
    - If XMIT_REQ=1, latch XMIT_Data into the shift register and go to START.
    - XMIT_ACK rises on the same edge; TX goes low on the same edge (latency: 1 clk from REQ sampled high).
  - START: TX=0 for CLKS_PER_BIT clocks. At bit end go to DATA with bit counter=0.
  - DATA: TX=shift[0] for CLKS_PER_BIT clocks. At bit end, shift right and increment the bit counter. After bit 7, go to PARITY if PARITY_EN is defined, otherwise STOP.
  - STOP: TX=1 for CLKS_PER_BIT×STOP_BITS clocks, then go to DONE.
  - DONE: TX=1.
    - If XMIT_REQ=0, drive XMIT_ACK=0 and go to IDLE.
    - Otherwise stay in DONE; no retransmit.
- Handshake rules:
  - XMIT_Data is sampled only on the IDLE→START edge. Changes afterward have no effect.
  - XMIT_REQ may fall at any time after XMIT_ACK rises. The frame always completes in full.
  - ACK falls no earlier than the first clock of DONE.
  - A new REQ is accepted only in IDLE, and only after ACK has been low for ≥1 clk. No back-to-back frames without the four-phase return.
- Frame length: (10 + STOP_BITS - 1) × CLKS_PER_BIT clocks, plus CLKS_PER_BIT if PARITY_EN is defined.
- Illegal STOP_BITS values are treated as 1.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP.
  - TX = even parity (XOR of the 8 latched data bits) for CLKS_PER_BIT clocks.
  - Frame becomes 8E1 (or 8E2).
- Undefined: no PARITY state and no parity logic; 8N1/8N2 only.

Test Plan:
1. Reset: hold clr=0 for 5 clk with REQ=1 → TX=1, XMIT_ACK=0, BUSY=0 throughout. Release clr → ACK rises 1 clk later and TX falls.
2. Byte 0x55, CLKS_PER_BIT=16, STOP_BITS=1 → TX sequence 0,1,0,1,0,1,0,1,0,1, each exactly 16 clk. BUSY high for 160 clk. ACK drops 1 clk after REQ low in DONE.
3. Byte 0xA3, REQ dropped and XMIT_Data changed to 0xFF during DATA → full frame sends 0xA3 (LSB first 1,1,0,0,0,1,0,1). ACK falls on the first DONE clock.
4. REQ held high past frame end → stays in DONE with TX=1 and ACK=1, no second frame. Drop REQ → IDLE. Raise REQ with 0x00 → new frame starts.
5. STOP_BITS=2, byte 0xFF → TX high for 32 clk after bit 7 (CLKS_PER_BIT=16). Total frame 176 clk.
6. Build with UART_TX_PARITY_EN, bytes 0x07 and 0x03 → parity bit 1 and 0 respectively, one bit time before stop. Assert clr mid-parity → TX=1 immediately, state IDLE.
